// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Debounced pushbutton input. A raw, asynchronous, bouncing
//               button pin passes through a 2-FF synchronizer into a 4-state
//               debounce FSM. The block produces a clean pressed level,
//               one-cycle press/release pulses, a one-cycle long-press pulse
//               and a held level that runs from the long press to the release.
// Parameters  : DB_BITS    - debounce counter width; the input must be stable
//                            for 2^DB_BITS cycles to be accepted (1..24)
//               LONG_BITS  - long-press counter width; long press fires
//                            2^LONG_BITS cycles after the press is accepted (1..28)
//               ACTIVE_LOW - 1: pin reads 0 when pressed; 0: pin reads 1
// Ports       : clk         in  - single clock, rising edge
//               rst_n       in  - asynchronous active-low reset
//               btn_in      in  - raw button pin (asynchronous, bouncing)
//               btn_level   out - debounced state, 1 = pressed
//               btn_press   out - one-cycle pulse on accepted press
//               btn_release out - one-cycle pulse on accepted release
//               btn_long    out - one-cycle pulse at the long-press threshold
//               btn_held    out - high from btn_long until btn_release
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DB_BITS    = 16,
    parameter int LONG_BITS  = 24,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_held
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic                   sync1_q,      sync1_d;
    logic                   sync2_q,      sync2_d;
    logic [DB_BITS-1:0]     dcnt_q,       dcnt_d;
    logic [LONG_BITS-1:0]   lcnt_q,       lcnt_d;
    logic                   long_flag_q,  long_flag_d;
    logic                   level_q,      level_d;
    logic                   press_q,      press_d;
    logic                   release_q,    release_d;
    logic                   long_pulse_q, long_pulse_d;
    logic                   held_q,       held_d;

    // Synchronized pin normalized so that 1 always means "pressed".
    logic                   pressed_s;
    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        sync1_d      = btn_in;
        sync2_d      = sync1_q;
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        lcnt_d       = lcnt_q;
        long_flag_d  = long_flag_q;
        level_d      = level_q;
        held_d       = held_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_pulse_d = 1'b0;

        case (state_q)
            RELEASED: begin
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end

            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = RELEASED;
                end else if (dcnt_q == '1) begin
                    state_d     = PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    lcnt_d      = '0;
                    long_flag_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DB_BITS'(1);
                end
            end

            PRESSED: begin
                // lcnt holds while the release is being qualified so a
                // bounce only pauses long-press timing, never restarts it.
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (!long_flag_q) begin
                    if (lcnt_q == '1) begin
                        long_pulse_d = 1'b1;
                        long_flag_d  = 1'b1;
                        held_d       = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q + LONG_BITS'(1);
                    end
                end
            end

            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                end else if (dcnt_q == '1) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    held_d    = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DB_BITS'(1);
                end
            end

            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronizer resets to the released pin level so that a
            // button held through reset is seen as a fresh press.
            sync1_q      <= ACTIVE_LOW;
            sync2_q      <= ACTIVE_LOW;
            state_q      <= RELEASED;
            dcnt_q       <= '0;
            lcnt_q       <= '0;
            long_flag_q  <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_pulse_q <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            lcnt_q       <= lcnt_d;
            long_flag_q  <= long_flag_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_pulse_q <= long_pulse_d;
            held_q       <= held_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_pulse_q;
    assign btn_held    = held_q;

endmodule
`default_nettype wire

// File: doc/button_debounce.md
# button_debounce

Debounced pushbutton input for the Dragon board: the input-side counterpart of the free-running-counter LED driver. A raw, asynchronous, bouncing button pin goes through a 2-FF synchronizer and a 4-state debounce FSM. The block emits a clean level, one-cycle press/release pulses, and a long-press indication. It sits between the board pin and user logic, such as LED mode selection.

## Interface
- `DB_BITS`, default 16: debounce counter width; an input must be stable for 2^DB_BITS cycles to be accepted. Legal range 1..24.
- `LONG_BITS`, default 24: long-press counter width; long press fires after 2^LONG_BITS cycles in PRESSED. Legal range 1..28.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed; 0 means it reads 1 when pressed.

- `clk`  input  1: single clock; all logic on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `btn_in`  input  1: raw button pin; asynchronous, may bounce.
- `btn_level`  output  1: debounced state; 1 = pressed.
- `btn_press`  output  1: one-cycle pulse on accepted press.
- `btn_release`  output  1: one-cycle pulse on accepted release.
- `btn_long`  output  1: one-cycle pulse when the long-press threshold is reached.
- `btn_held`  output  1: level; high from the `btn_long` pulse until `btn_release`.

## Operation
- Synchronizer: `sync1 <= btn_in`, `sync2 <= sync1`.
  - `s = sync2 XOR ACTIVE_LOW`, normalized so that 1 = pressed.
  - Reset value of `sync1`/`sync2`: the released pin level, i.e. `ACTIVE_LOW`.
- Debounce counter `dcnt`, DB_BITS wide, and long counter `lcnt`, LONG_BITS wide. Both are unsigned, and neither wraps.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is RELEASED.
- **RELEASED**
  - `s=1`: go to PRESS_WAIT, `dcnt<=0`.
- **PRESS_WAIT**
  - `s=0`: return to RELEASED. No pulse.
  - `s=1` and `dcnt` = all-ones: go to PRESSED. Set `btn_level<=1`, pulse `btn_press`, `lcnt<=0`, clear the long flag.
  - Otherwise: `dcnt++`.
- **PRESSED**
  - `s=0`: go to RELEASE_WAIT, `dcnt<=0`. `lcnt` holds.
  - Otherwise, if the long flag is clear:
    - If `lcnt` = all-ones: pulse `btn_long`, set the long flag and `btn_held`.
    - Else: `lcnt++`.
  - If the long flag is set, `lcnt` holds; there is no repeat.
- **RELEASE_WAIT**
  - `s=1`: return to PRESSED. No pulse. `lcnt` and the long flag are preserved, so a bounce does not restart long-press timing.
  - `s=0` and `dcnt` = all-ones: go to RELEASED. Set `btn_level<=0`, `btn_held<=0`, pulse `btn_release`.
  - Otherwise: `dcnt++`.
- Boundary behaviour:
  - Any bounce shorter than 2^DB_BITS cycles produces no output activity.
  - `btn_press` and `btn_release` can never assert in the same cycle.
  - `btn_long` can never assert in the same cycle as `btn_press`.
- Reset asserted mid-operation: everything returns to RELEASED immediately; all outputs go to 0 and no pulse is generated.
  - If the button is still held when `rst_n` deasserts, a normal press is reported after the debounce time.

## Timing
- Reset values: `btn_level`, `btn_press`, `btn_release`, `btn_long`, `btn_held`, `dcnt`, `lcnt` and the long flag are all 0.
- All outputs are registered; there is no combinational path from `btn_in`.
- Press latency for a clean edge, counting the first edge that samples the new pin value as edge 1:
  - Edge 3: enter PRESS_WAIT with `dcnt=0`.
  - Edge 2^DB_BITS+3: update `btn_level` and `btn_press`.
  - `btn_press` is high for exactly the cycle after that edge.
- Release latency: identical, 2^DB_BITS+3 edges.
- Long press: `btn_long` asserts on the edge 2^LONG_BITS cycles after the PRESSED entry edge. Cycles spent in RELEASE_WAIT bounces extend this one-for-one.

## Test plan
All scenarios use DB_BITS=4 and LONG_BITS=6.
- Reset, then `btn_in=1` with ACTIVE_LOW=1 -> all outputs 0; the FSM stays in RELEASED indefinitely.
- Clean press: drive `btn_in` 1→0 and hold -> `btn_press` high for 1 cycle and `btn_level` rises exactly 19 edges after the first sampling edge. No `btn_release`.
- Bouncy press: 0/1 toggles every 3 cycles for 40 cycles, then steady 0 -> a single `btn_press`, 19 edges after the last toggle is sampled.
- Long press: hold for 200 cycles after `btn_press` -> `btn_long` pulses once, 64 cycles after the PRESSED entry. `btn_held` is high until release, and there is no second `btn_long`.
- Release with a 5-cycle bounce while held -> no `btn_release`, and `lcnt` is not restarted. A subsequent clean release gives `btn_release` 19 edges later, with `btn_level` and `btn_held` dropping together.
- Assert `rst_n` low during PRESS_WAIT and during PRESSED -> outputs go to 0 asynchronously with no pulses. On deassert with the button still held, `btn_press` follows after 19 edges.
